mcu_div_seq: RTL and testbench

- Self-contained, parametrised iterative restoring divider for the MCU execute stage.
- Successor to the ALU-sharing divider. It owns its subtractor, so it needs no ALU borrow.
- It has its own FSM, a valid/ready request and response handshake, a flush input, radix selection and RISC-V M-extension corner-case semantics (DIV/DIVU/REM/REMU).
- Sits between the decode/issue logic and writeback.

---
 rtl/mcu_div_pkg.sv | 36 +++
 rtl/mcu_div_step.sv | 24 ++
 rtl/mcu_div_seq.sv | 189 ++++++++++++++++++
 tb/tb_mcu_div_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Width-dependent patterns are built at MAX_XLEN and sliced by the user.
package mcu_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int MAX_XLEN = 64;

    // Values for the default configuration (XLEN=32, one bit per cycle)
    localparam int XLEN_DEF = 32;
    localparam int BPC_DEF  = 1;
    localparam int ITER     = XLEN_DEF / BPC_DEF;
    localparam int CNT_W    = $clog2(ITER + 1);

    function automatic int iterCount(input int xlen, input int bpc);
        return xlen / bpc;
    endfunction

    function automatic int cntWidth(input int xlen, input int bpc);
        return $clog2((xlen / bpc) + 1);
    endfunction

    function automatic logic [MAX_XLEN-1:0] intMinPat(input int xlen);
        return {{(MAX_XLEN-1){1'b0}}, 1'b1} << (xlen - 1);
    endfunction

    function automatic logic [MAX_XLEN-1:0] onesPat(input int xlen);
        return {MAX_XLEN{1'b1}} >> (MAX_XLEN - xlen);
    endfunction

endpackage

// File: rtl/mcu_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor magnitude when it fits, and report the quotient bit.
module mcu_div_step
    import mcu_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0] rem_i,
    input  logic [XLEN:0] div_i,
    input  logic          bit_i,
    output logic [XLEN:0] rem_o,
    output logic          qbit_o
);

    logic [XLEN:0] shifted;
    logic          unusedMsb;

    // The incoming partial remainder is always below the divisor, so its top bit is zero
    assign unusedMsb = rem_i[XLEN];
    assign shifted   = {rem_i[XLEN-1:0], bit_i};
    assign qbit_o    = (shifted >= div_i);
    assign rem_o     = qbit_o ? (shifted - div_i) : shifted;

endmodule

// File: rtl/mcu_div_seq.sv
// Iterative restoring divider with RISC-V DIV/DIVU/REM/REMU semantics,
// valid/ready request and response handshakes and a pipeline flush.
module mcu_div_seq
    import mcu_div_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BITS_PER_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_op1,
    input  logic [XLEN-1:0] req_op2,
    input  logic            req_signed,
    input  logic            req_rem,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_dbz
);

    localparam int ITERS = iterCount(XLEN, BITS_PER_CYC);
    localparam int CW    = cntWidth(XLEN, BITS_PER_CYC);

    localparam logic [MAX_XLEN-1:0] INT_MIN_W = intMinPat(XLEN);
    localparam logic [MAX_XLEN-1:0] ONES_W    = onesPat(XLEN);
    localparam logic [XLEN-1:0]     INT_MIN   = INT_MIN_W[XLEN-1:0];
    localparam logic [XLEN-1:0]     ALL_ONES  = ONES_W[XLEN-1:0];
    localparam logic [XLEN-1:0]     ONE       = XLEN'(1);

    div_state_e      state_q,  state_d;
    logic [XLEN:0]   rem_q,    rem_d;
    logic [XLEN-1:0] quo_q,    quo_d;
    logic [XLEN:0]   div_q,    div_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            remSel_q, remSel_d;
    logic            negQ_q,   negQ_d;
    logic            negR_q,   negR_d;
    logic [XLEN-1:0] data_q,   data_d;
    logic            dbz_q,    dbz_d;

    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            isZero;
    logic            isOvf;
    logic [XLEN:0]   stepRem;
    logic [XLEN-1:0] stepQuo;
    logic [XLEN-1:0] quoOut;
    logic [XLEN-1:0] remOut;

    logic [XLEN:0]         chainRem [BITS_PER_CYC+1];
    logic [BITS_PER_CYC-1:0] qBits;

    // quo_q doubles as the dividend shifter: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    assign chainRem[0] = rem_q;

    for (genvar j = 0; j < BITS_PER_CYC; j++) begin : g_step
        mcu_div_step #(
            .XLEN (XLEN)
        ) u_step (
            .rem_i  (chainRem[j]),
            .div_i  (div_q),
            .bit_i  (quo_q[XLEN-1-j]),
            .rem_o  (chainRem[j+1]),
            .qbit_o (qBits[BITS_PER_CYC-1-j])
        );
    end

    assign stepRem = chainRem[BITS_PER_CYC];
    assign stepQuo = {quo_q[XLEN-1-BITS_PER_CYC:0], qBits};

    assign mag1   = (req_signed && req_op1[XLEN-1]) ? (~req_op1 + ONE) : req_op1;
    assign mag2   = (req_signed && req_op2[XLEN-1]) ? (~req_op2 + ONE) : req_op2;
    assign isZero = (req_op2 == '0);
    assign isOvf  = req_signed && (req_op1 == INT_MIN) && (req_op2 == ALL_ONES);

    assign quoOut = negQ_q ? (~quo_q + ONE) : quo_q;
    assign remOut = negR_q ? (~rem_q[XLEN-1:0] + ONE) : rem_q[XLEN-1:0];

    // Corner cases preload the final answer and pass through FIX, so every
    // response leaves one edge after its result register settles.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        remSel_d = remSel_q;
        negQ_d   = negQ_q;
        negR_d   = negR_q;
        data_d   = data_q;
        dbz_d    = dbz_q;

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    remSel_d = req_rem;
                    dbz_d    = isZero;
                    cnt_d    = CW'(ITERS);
                    if (isZero) begin
                        quo_d   = ALL_ONES;
                        rem_d   = {1'b0, req_op1};
                        div_d   = '0;
                        negQ_d  = 1'b0;
                        negR_d  = 1'b0;
                        state_d = FIX;
                    end else if (isOvf) begin
                        quo_d   = INT_MIN;
                        rem_d   = '0;
                        div_d   = '0;
                        negQ_d  = 1'b0;
                        negR_d  = 1'b0;
                        state_d = FIX;
                    end else begin
                        quo_d   = mag1;
                        rem_d   = '0;
                        div_d   = {1'b0, mag2};
                        negQ_d  = req_signed && (req_op1[XLEN-1] ^ req_op2[XLEN-1]);
                        negR_d  = req_signed && req_op1[XLEN-1];
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = stepRem;
                    quo_d = stepQuo;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    data_d  = remSel_q ? remOut : quoOut;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            remSel_q <= 1'b0;
            negQ_q   <= 1'b0;
            negR_q   <= 1'b0;
            data_q   <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            remSel_q <= remSel_d;
            negQ_q   <= negQ_d;
            negR_q   <= negR_d;
            data_q   <= data_d;
            dbz_q    <= dbz_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_data  = data_q;
    assign resp_dbz   = dbz_q;

endmodule

// File: tb/tb_mcu_div_seq.sv
// Scoreboard bench driving a one-bit-per-cycle and a four-bit-per-cycle
// divider in lockstep and comparing both against an arithmetic reference.
module tb_mcu_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic        req_signed = 1'b0;
    logic        req_rem = 1'b0;
    logic        flush = 1'b0;
    logic        resp_ready = 1'b1;

    logic        rr1, rv1, dz1;
    logic [31:0] rd1;
    logic        rr4, rv4, dz4;
    logic [31:0] rd4;

    int cycle = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        dbz;
        int          t0;
        int          lat;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    mcu_div_seq #(.XLEN(32), .BITS_PER_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr1),
        .req_op1(req_op1), .req_op2(req_op2), .req_signed(req_signed), .req_rem(req_rem),
        .flush(flush), .resp_valid(rv1), .resp_ready(resp_ready),
        .resp_data(rd1), .resp_dbz(dz1)
    );

    mcu_div_seq #(.XLEN(32), .BITS_PER_CYC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr4),
        .req_op1(req_op1), .req_op2(req_op2), .req_signed(req_signed), .req_rem(req_rem),
        .flush(flush), .resp_valid(rv4), .resp_ready(resp_ready),
        .resp_data(rd4), .resp_dbz(dz4)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, which truncates toward zero and
    // gives the remainder the dividend's sign.
    function automatic logic [32:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn, input logic rem);
        longint la, lb, lq, lr;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            if (sgn) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
            end else begin
                la = longint'({32'd0, a});
                lb = longint'({32'd0, b});
            end
            lq = la / lb;
            lr = la % lb;
            q = lq[31:0];
            r = lr[31:0];
        end
        return {(b == 32'd0), (rem ? r : q)};
    endfunction

    // Responses are scored at the handshake; with resp_ready held high
    // that is also the first cycle resp_valid is seen.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && resp_ready && rv1) begin
            if (q1.size() == 0) begin
                checkOutput("b1_unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                checkOutput("b1_data", {32'd0, rd1}, {32'd0, e.data});
                checkOutput("b1_dbz", {63'd0, dz1}, {63'd0, e.dbz});
                if (e.lat >= 0) checkOutput("b1_latency", 64'(cycle - e.t0), 64'(e.lat));
            end
        end
        if (rst_n && resp_ready && rv4) begin
            if (q4.size() == 0) begin
                checkOutput("b4_unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = q4.pop_front();
                checkOutput("b4_data", {32'd0, rd4}, {32'd0, e.data});
                checkOutput("b4_dbz", {63'd0, dz4}, {63'd0, e.dbz});
                if (e.lat >= 0) checkOutput("b4_latency", 64'(cycle - e.t0), 64'(e.lat));
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic sgn, input logic rem, input bit track);
        int n = 0;
        exp_t e;
        logic [32:0] r;
        bit special;
        while (!(rr1 && rr4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(rr1 && rr4)) begin
            checkOutput("ready_timeout", {62'd0, rr1, rr4}, 64'd3);
            return;
        end
        req_op1 = a;
        req_op2 = b;
        req_signed = sgn;
        req_rem = rem;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op1 = $urandom;
        req_op2 = $urandom;
        if (track) begin
            r = refModel(a, b, sgn, rem);
            special = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
            e.data = r[31:0];
            e.dbz = r[32];
            e.t0 = cycle;
            e.lat = !resp_ready ? -1 : (special ? 1 : 33);
            q1.push_back(e);
            e.lat = !resp_ready ? -1 : (special ? 1 : 9);
            q4.push_back(e);
        end
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0 || q4.size() != 0) begin
            checkOutput("resp_timeout", 64'(q1.size() + q4.size()), 64'd0);
            q1.delete();
            q4.delete();
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, {62'd0, rr1, rr4}, 64'd3);
        checkOutput({tag, "_resp_valid"}, {62'd0, rv1, rv4}, 64'd0);
        checkOutput({tag, "_resp_data"}, {rd1, rd4}, 64'd0);
        checkOutput({tag, "_resp_dbz"}, {62'd0, dz1, dz4}, 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic s, m;
        logic [32:0] r;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus(32'd100, 32'd7, 1'b0, 1'b0, 1'b1);          waitIdle(60);
        applyStimulus(32'd100, 32'd7, 1'b0, 1'b1, 1'b1);          waitIdle(60);
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b1);    waitIdle(60);
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b1);    waitIdle(60);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);    waitIdle(60);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1);    waitIdle(60);
        applyStimulus(32'd5, 32'd0, 1'b1, 1'b0, 1'b1);            waitIdle(60);
        applyStimulus(32'd5, 32'd0, 1'b1, 1'b1, 1'b1);            waitIdle(60);
        applyStimulus(32'd5, 32'd0, 1'b0, 1'b0, 1'b1);            waitIdle(60);
        applyStimulus(32'd5, 32'd0, 1'b0, 1'b1, 1'b1);            waitIdle(60);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1); waitIdle(60);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1); waitIdle(60);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1); waitIdle(60);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1); waitIdle(60);

        $display("[TB] backpressure");
        resp_ready = 1'b0;
        applyStimulus(32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 60 && !rv1; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", {62'd0, rv1, rv4}, 64'd3);
            checkOutput("bp_data", {rd1, rd4}, {32'd14, 32'd14});
            checkOutput("bp_ready", {62'd0, rr1, rr4}, 64'd0);
        end
        resp_ready = 1'b1;
        waitIdle(10);
        @(negedge clk);
        checkOutput("bp_ready_after", {62'd0, rr1, rr4}, 64'd3);

        $display("[TB] flush while idle");
        req_valid = 1'b1;
        flush = 1'b1;
        req_op1 = 32'd9;
        req_op2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        checkOutput("idle_flush_ready", {62'd0, rr1, rr4}, 64'd3);

        $display("[TB] flush mid-calc");
        applyStimulus(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_ready", {62'd0, rr1, rr4}, 64'd3);
        checkOutput("flush_valid", {62'd0, rv1, rv4}, 64'd0);
        repeat (40) @(negedge clk);

        $display("[TB] reset mid-calc");
        applyStimulus(32'd12345, 32'd17, 1'b1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        applyStimulus(32'd12345, 32'd17, 1'b1, 1'b1, 1'b1);
        waitIdle(60);

        $display("[TB] random regression");
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(1, 15));
                1: b = 32'd0;
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            r = refModel(a, b, s, m);
            if (i == 0) checkOutput("ref_sanity", {31'd0, r}, {31'd0, refModel(a, b, s, m)} ^ 64'd0);
            applyStimulus(a, b, s, m, 1'b1);
            waitIdle(60);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
